// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and encodings for the decode/execute control path.
// Reused by the ID/EX and EX/MEM control stages.
package riscv_pipe_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic [2:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic [2:0] branch_sel;
        logic       control_e_adder;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // An empty decode slot may carry stale decoder outputs; it must never write state.
    function automatic ctrl_t gate_writes(input ctrl_t c, input logic valid);
        ctrl_t g;
        g           = c;
        g.mem_write = c.mem_write & valid;
        g.reg_write = c.reg_write & valid;
        return g;
    endfunction

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Load-use detection and per-cycle stall/flush priority for the ID/EX register.
// Purely combinational; the owning stage applies hold_e/bubble_e to its flops.
module id_ex_hazard_detect
    import riscv_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  valid_e,
    input  logic                  reg_write_e,
    input  logic [1:0]            result_src_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  valid_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic                  pc_src_e,
    input  logic                  stall_ext,
    output logic                  load_use,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  hold_e,
    output logic                  bubble_e,
    output logic                  stall_evt,
    output logic                  flush_evt
);

    always_comb begin
        load_use = valid_e & reg_write_e & (result_src_e == RES_MEM) & (rd_e != '0)
                 & valid_d & ((rd_e == rs1_d) | (rd_e == rs2_d));

        stall_f   = 1'b0;
        stall_d   = 1'b0;
        flush_d   = 1'b0;
        hold_e    = 1'b0;
        bubble_e  = 1'b0;
        stall_evt = 1'b0;
        flush_evt = 1'b0;

        // External hold freezes everything, including a pending redirect.
        if (stall_ext) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            hold_e  = 1'b1;
        end else if (pc_src_e) begin
            flush_d   = 1'b1;
            bubble_e  = 1'b1;
            flush_evt = 1'b1;
        end else if (load_use) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            bubble_e  = 1'b1;
            stall_evt = 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control pipeline register with load-use stall and branch/jump flush.
// Optional hazard counters (stall_cnt, flush_cnt) are built when HAZ_STATS_EN is defined.
module id_ex_ctrl_stage
    import riscv_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  valid_d,
    input  logic                  mem_write_d,
    input  logic                  reg_write_d,
    input  logic                  branch_d,
    input  logic                  jump_d,
    input  logic                  control_e_adder_d,
    input  logic [2:0]            alu_src_b_d,
    input  logic [1:0]            result_src_d,
    input  logic [1:0]            alu_op_d,
    input  logic [2:0]            branch_sel_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  pc_src_e,
    input  logic                  stall_ext,
    output logic                  mem_write_e,
    output logic                  reg_write_e,
    output logic                  branch_e,
    output logic                  jump_e,
    output logic                  control_e_adder_e,
    output logic [2:0]            alu_src_b_e,
    output logic [1:0]            result_src_e,
    output logic [1:0]            alu_op_e,
    output logic [2:0]            branch_sel_e,
    output logic [REG_ADDR_W-1:0] rd_e,
    output logic                  valid_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d
`ifdef HAZ_STATS_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    ctrl_t                 ctrl_d;
    ctrl_t                 ctrl_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  valid_q;
    logic                  load_use;
    logic                  hold_e;
    logic                  bubble_e;
    logic                  stall_evt;
    logic                  flush_evt;

    always_comb begin
        ctrl_d.mem_write       = mem_write_d;
        ctrl_d.reg_write       = reg_write_d;
        ctrl_d.branch          = branch_d;
        ctrl_d.jump            = jump_d;
        ctrl_d.alu_src_b       = alu_src_b_d;
        ctrl_d.result_src      = result_src_d;
        ctrl_d.alu_op          = alu_op_d;
        ctrl_d.branch_sel      = branch_sel_d;
        ctrl_d.control_e_adder = control_e_adder_d;
    end

    id_ex_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .valid_e      (valid_q),
        .reg_write_e  (ctrl_q.reg_write),
        .result_src_e (ctrl_q.result_src),
        .rd_e         (rd_q),
        .valid_d      (valid_d),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .pc_src_e     (pc_src_e),
        .stall_ext    (stall_ext),
        .load_use     (load_use),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .hold_e       (hold_e),
        .bubble_e     (bubble_e),
        .stall_evt    (stall_evt),
        .flush_evt    (flush_evt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q  <= CTRL_BUBBLE;
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else if (!hold_e) begin
            if (bubble_e) begin
                ctrl_q  <= CTRL_BUBBLE;
                rd_q    <= '0;
                valid_q <= 1'b0;
            end else begin
                ctrl_q  <= gate_writes(ctrl_d, valid_d);
                rd_q    <= rd_d;
                valid_q <= valid_d;
            end
        end
    end

    assign mem_write_e       = ctrl_q.mem_write;
    assign reg_write_e       = ctrl_q.reg_write;
    assign branch_e          = ctrl_q.branch;
    assign jump_e            = ctrl_q.jump;
    assign control_e_adder_e = ctrl_q.control_e_adder;
    assign alu_src_b_e       = ctrl_q.alu_src_b;
    assign result_src_e      = ctrl_q.result_src;
    assign alu_op_e          = ctrl_q.alu_op;
    assign branch_sel_e      = ctrl_q.branch_sel;
    assign rd_e              = rd_q;
    assign valid_e           = valid_q;

`ifdef HAZ_STATS_EN
    // Saturating so a long-running profile never wraps back to a small count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_evt && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    logic unused_load_use;
    assign unused_load_use = load_use ^ stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Randomized scoreboard bench for id_ex_ctrl_stage; a slot-level model predicts E and strobes.
// With HAZ_STATS_EN the counters are built narrow so saturation is reachable.
`timescale 1ns/1ps
module tb_id_ex_ctrl_stage;

    localparam int AW = 5;
`ifdef HAZ_STATS_EN
    localparam int CW = 4;
`else
    localparam int CW = 32;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          valid_d, mem_write_d, reg_write_d, branch_d, jump_d, control_e_adder_d;
    logic [2:0]    alu_src_b_d, branch_sel_d;
    logic [1:0]    result_src_d, alu_op_d;
    logic [AW-1:0] rs1_d, rs2_d, rd_d;
    logic          pc_src_e, stall_ext;
    logic          mem_write_e, reg_write_e, branch_e, jump_e, control_e_adder_e;
    logic [2:0]    alu_src_b_e, branch_sel_e;
    logic [1:0]    result_src_e, alu_op_e;
    logic [AW-1:0] rd_e;
    logic          valid_e, stall_f, stall_d, flush_d;
`ifdef HAZ_STATS_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    typedef struct packed {
        logic       valid, mw, rw, br, jp, cea;
        logic [2:0] asb;
        logic [1:0] rs, aop;
        logic [2:0] bs;
        logic [4:0] rd;
    } e_t;

    typedef struct packed {
        logic       valid, mw, rw, br, jp, cea;
        logic [2:0] asb;
        logic [1:0] rs, aop;
        logic [2:0] bs;
        logic [4:0] rs1, rs2, rd;
        logic       pc_src, hold;
    } d_t;

    typedef struct packed { logic sf, sd, fl; } c_t;

    e_t exp_e[$];
    c_t exp_c[$];
    e_t model;
    e_t act_e;
    int tests = 0;
    int fails = 0;
    int stall_events = 0;
    int flush_events = 0;

    always #5 clk = ~clk;

    id_ex_ctrl_stage #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .valid_d(valid_d), .mem_write_d(mem_write_d), .reg_write_d(reg_write_d),
        .branch_d(branch_d), .jump_d(jump_d), .control_e_adder_d(control_e_adder_d),
        .alu_src_b_d(alu_src_b_d), .result_src_d(result_src_d), .alu_op_d(alu_op_d),
        .branch_sel_d(branch_sel_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .pc_src_e(pc_src_e), .stall_ext(stall_ext),
        .mem_write_e(mem_write_e), .reg_write_e(reg_write_e), .branch_e(branch_e),
        .jump_e(jump_e), .control_e_adder_e(control_e_adder_e), .alu_src_b_e(alu_src_b_e),
        .result_src_e(result_src_e), .alu_op_e(alu_op_e), .branch_sel_e(branch_sel_e),
        .rd_e(rd_e), .valid_e(valid_e), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d)
`ifdef HAZ_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    assign act_e = {valid_e, mem_write_e, reg_write_e, branch_e, jump_e, control_e_adder_e,
                    alu_src_b_e, result_src_e, alu_op_e, branch_sel_e, rd_e};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic d_t rnd();
        d_t d;
        d        = '0;
        d.valid  = ($urandom_range(0, 7) != 0);
        d.mw     = 1'($urandom);
        d.rw     = 1'($urandom);
        d.br     = 1'($urandom);
        d.jp     = 1'($urandom);
        d.cea    = 1'($urandom);
        d.asb    = 3'($urandom);
        d.rs     = 2'($urandom);
        d.aop    = 2'($urandom);
        d.bs     = 3'($urandom);
        d.rs1    = 5'($urandom_range(0, 7));
        d.rs2    = 5'($urandom_range(0, 7));
        d.rd     = 5'($urandom_range(0, 7));
        d.pc_src = ($urandom_range(0, 7) == 0);
        d.hold   = ($urandom_range(0, 7) == 0);
        return d;
    endfunction

    // A quiet, valid instruction; directed cases override the fields they care about.
    function automatic d_t base();
        d_t d;
        d       = rnd();
        d.valid = 1'b1;
        d.pc_src = 1'b0;
        d.hold  = 1'b0;
        d.rs1   = 5'd20;
        d.rs2   = 5'd21;
        return d;
    endfunction

    task automatic step(input d_t d);
        logic lu;
        c_t   c;
        @(negedge clk);
        valid_d = d.valid; mem_write_d = d.mw; reg_write_d = d.rw; branch_d = d.br;
        jump_d = d.jp; control_e_adder_d = d.cea; alu_src_b_d = d.asb; result_src_d = d.rs;
        alu_op_d = d.aop; branch_sel_d = d.bs; rs1_d = d.rs1; rs2_d = d.rs2; rd_d = d.rd;
        pc_src_e = d.pc_src; stall_ext = d.hold;
        // A real load in E whose nonzero target is read by a real instruction in D.
        lu = model.valid && model.rw && (model.rs == 2'b01) && (model.rd != 0) && d.valid
             && ((model.rd == d.rs1) || (model.rd == d.rs2));
        c = '0;
        if (d.hold) begin
            c.sf = 1'b1; c.sd = 1'b1;
        end else if (d.pc_src) begin
            c.fl = 1'b1;
            model = '0;
            flush_events++;
        end else if (lu) begin
            c.sf = 1'b1; c.sd = 1'b1;
            model = '0;
            stall_events++;
        end else begin
            model.valid = d.valid;
            model.mw    = d.mw & d.valid;
            model.rw    = d.rw & d.valid;
            model.br    = d.br;
            model.jp    = d.jp;
            model.cea   = d.cea;
            model.asb   = d.asb;
            model.rs    = d.rs;
            model.aop   = d.aop;
            model.bs    = d.bs;
            model.rd    = d.rd;
        end
        exp_c.push_back(c);
        exp_e.push_back(model);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_e"}, 32'(act_e), 32'd0);
        chk({name, "_strobes"}, {29'd0, stall_f, stall_d, flush_d}, 32'd0);
    endtask

    task automatic model_reset();
        model = '0;
        stall_events = 0;
        flush_events = 0;
    endtask

    initial begin : monitor
        c_t c;
        e_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_c.size() > 0) begin
                c = exp_c.pop_front();
                tests++;
                if ({stall_f, stall_d, flush_d} !== c) begin
                    fails++;
                    $display("FAIL strobes: got sf/sd/fl=%b%b%b expected %b%b%b",
                             stall_f, stall_d, flush_d, c.sf, c.sd, c.fl);
                end
            end
            @(posedge clk);
            #1;
            if (exp_e.size() > 0) begin
                e = exp_e.pop_front();
                tests++;
                if (act_e !== e) begin
                    fails++;
                    $display("FAIL e_slot: got %h expected %h (valid %b/%b rd %0d/%0d)",
                             act_e, e, valid_e, e.valid, rd_e, e.rd);
                end
            end
        end
    end

    initial begin : stim
        d_t d;
        reset_n = 1'b0;
        d = rnd();
        valid_d = d.valid; mem_write_d = 1'b1; reg_write_d = 1'b1; branch_d = d.br;
        jump_d = d.jp; control_e_adder_d = d.cea; alu_src_b_d = d.asb; result_src_d = d.rs;
        alu_op_d = d.aop; branch_sel_d = d.bs; rs1_d = d.rs1; rs2_d = d.rs2; rd_d = d.rd;
        pc_src_e = 1'b0; stall_ext = 1'b0;
        model_reset();
        #3;
        check_all_zero("reset");
        #14;
        check_all_zero("reset_clocked");
        reset_n = 1'b1;

        // R-type pass-through
        d = base(); d.rw = 1'b1; d.aop = 2'b10; d.rd = 5'd5; d.rs = 2'b00; d.mw = 1'b0;
        step(d);

        // Load rd=7 then consumer on rs2: one stall cycle, then the consumer loads.
        d = base(); d.rw = 1'b1; d.rs = 2'b01; d.rd = 5'd7;
        step(d);
        d = base(); d.rs2 = 5'd7; d.rd = 5'd9;
        step(d);
        step(d);

        // Load into x0 never stalls.
        d = base(); d.rw = 1'b1; d.rs = 2'b01; d.rd = 5'd0;
        step(d);
        d = base(); d.rs1 = 5'd0; d.rs2 = 5'd0;
        step(d);

        // Flush beats load-use.
        d = base(); d.rw = 1'b1; d.rs = 2'b01; d.rd = 5'd7;
        step(d);
        d = base(); d.rs1 = 5'd7; d.pc_src = 1'b1;
        step(d);

        // External hold with a pending redirect, then release.
        d = base(); d.rd = 5'd12;
        step(d);
        for (int i = 0; i < 3; i++) begin
            d = base(); d.hold = 1'b1; d.pc_src = 1'b1;
            step(d);
        end
        d = base(); d.pc_src = 1'b1;
        step(d);

        // Empty slot: fields pass through, writes and valid cleared.
        d = base(); d.valid = 1'b0; d.rw = 1'b1; d.mw = 1'b1; d.rd = 5'd3;
        step(d);

        // Reset in the middle of a load-use stall.
        d = base(); d.rw = 1'b1; d.rs = 2'b01; d.rd = 5'd6;
        step(d);
        d = base(); d.rs1 = 5'd6;
        step(d);
        #4;
        reset_n = 1'b0;
        #0.5;
        check_all_zero("reset_mid_stall");
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_reset();

        // Reset with a live instruction in E.
        d = base(); d.rw = 1'b1; d.rd = 5'd11;
        step(d);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #0.5;
        check_all_zero("reset_live_e");
        #1;
        reset_n = 1'b1;
        model_reset();

        for (int i = 0; i < 2000; i++) step(rnd());

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_c.size() + exp_e.size()), 32'd0);
`ifdef HAZ_STATS_EN
        chk("stall_cnt", 32'(stall_cnt),
            32'((stall_events > (1 << CW) - 1) ? (1 << CW) - 1 : stall_events));
        chk("flush_cnt", 32'(flush_cnt),
            32'((flush_events > (1 << CW) - 1) ? (1 << CW) - 1 : flush_events));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_ctrl_stage.md
Name: id_ex_ctrl_stage

Overview:
- Decode-to-execute pipeline register for the control bundle produced by the single-cycle control instruction decoder.
- Includes load-use hazard detection and branch/jump flush handling.
- Sits between the decode stage (decoder outputs, rs1/rs2/rd fields) and the execute stage (ALU, branch comparator, PC adder).
- Generates the fetch/decode stall and flush strobes for the IF and IF/ID registers.

Parameters:
- REG_ADDR_W, 5, register-index width
- CNT_W, 32, width of hazard statistics counters (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- valid_d  in  1  decode slot holds a real instruction
- mem_write_d, reg_write_d, branch_d, jump_d, control_e_adder_d  in  1 each  decoder controls
- alu_src_b_d  in  3  decoder ALU B-source select
- result_src_d  in  2  00 ALU, 01 memory, 10 PC+4
- alu_op_d  in  2  decoder ALU op class
- branch_sel_d  in  3  branch condition select
- rs1_d, rs2_d, rd_d  in  REG_ADDR_W each  decode register indices
- pc_src_e  in  1  EX resolved a taken branch or jump
- stall_ext  in  1  external hold (memory wait)
- mem_write_e, reg_write_e, branch_e, jump_e, control_e_adder_e  out  1 each  registered controls
- alu_src_b_e  out  3  registered
- result_src_e  out  2  registered
- alu_op_e  out  2  registered
- branch_sel_e  out  3  registered
- rd_e  out  REG_ADDR_W  registered
- valid_e  out  1  registered
- stall_f, stall_d  out  1  hold PC / IF-ID register (combinational)
- flush_d  out  1  clear IF-ID register (combinational)

Behaviour:
- Reset (async, reset_n=0): every registered output is 0, i.e. a bubble. Combinational outputs follow their equations.
- Bubble: all *_e outputs 0, including valid_e, rd_e and every write enable.
- load_use = valid_e & reg_write_e & (result_src_e==01) & (rd_e!=0) & valid_d & (rd_e==rs1_d | rd_e==rs2_d).
- Per-cycle priority, highest first:
  1. stall_ext=1: E holds its value; stall_f=stall_d=1; flush_d=0; pc_src_e ignored.
  2. pc_src_e=1: E loads a bubble; flush_d=1; stall_f=stall_d=0. Flush wins over load_use.
  3. load_use=1: E loads a bubble; stall_f=stall_d=1; flush_d=0.
  4. Otherwise: E loads the D bundle (latency 1 cycle); stall/flush=0.
- valid_d=0: the D bundle is loaded as-is but with valid_e=0 and all write enables forced to 0.
- Index x0: rd_d==0 leaves reg_write passed through unchanged; hazard logic never matches rd 0.
- Load-use stall lasts exactly 1 cycle: after the bubble, E no longer holds the load.
- reset_n asserted mid-stall or mid-flush: outputs go to bubble immediately. No state survives.

Optional Feature:
- Macro: HAZ_STATS_EN.
- Defined:
  - Adds outputs stall_cnt and flush_cnt, CNT_W each.
  - stall_cnt increments on each cycle where load_use is effective (priority 3); flush_cnt increments on each priority-2 cycle.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package riscv_pipe_pkg:
  - result_src encodings RES_ALU/RES_MEM/RES_PC4.
  - opcode constants.
  - packed struct ctrl_t bundling mem_write, reg_write, branch, jump, alu_src_b, result_src, alu_op, branch_sel, control_e_adder; reused by the EX/MEM stage.
- One natural sub-module: id_ex_hazard_detect, the combinational load_use and priority logic.

Test Plan:
- Reset: reset_n=0 with random D inputs -> all *_e=0; stall_f=stall_d=flush_d=0.
- Pass-through: D R-type (reg_write=1, alu_op=10, rd=5, valid=1) -> next cycle reg_write_e=1, alu_op_e=10, rd_e=5, valid_e=1.
- Load-use:
  - E holds load rd=7; D has rs2=7 -> stall_f=stall_d=1 that cycle; next cycle E is a bubble; the following cycle D is loaded.
  - Same with rd=0 -> no stall.
- Flush vs load-use: pc_src_e=1 while load_use=1 -> flush_d=1, stall_d=0; E is a bubble next cycle.
- External hold: stall_ext=1 for 3 cycles with pc_src_e=1 -> E unchanged, flush_d=0; on release, flush_d=1.
- HAZ_STATS_EN: 2 load-use events plus 1 flush -> stall_cnt=2, flush_cnt=1.
- HAZ_STATS_EN saturation: counters preset near max -> hold at all-ones.
